// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared widths, FSM state encoding and SPI mode type for the
//               SPI master shift engine.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int c_DATA_WIDE = 8;
    localparam int c_LEN_WIDE  = 16;
    localparam int c_DIV_WIDE  = 8;

    typedef logic [2:0] state_t;

    localparam state_t c_ST_IDLE  = 3'd0;
    localparam state_t c_ST_SETUP = 3'd1;
    localparam state_t c_ST_LOAD  = 3'd2;
    localparam state_t c_ST_SHIFT = 3'd3;
    localparam state_t c_ST_HOLD  = 3'd4;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

endpackage
`default_nettype wire

// File: rtl/spi_sclk_gen.sv
`default_nettype none
// ============================================================================
// Module      : spi_sclk_gen
// Description : Half-period divider, SCLK level and leading/trailing edge
//               strobes for the SPI master shift engine.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int DIV_WIDE = c_DIV_WIDE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_run,
    input  logic                i_shift,
    input  logic                i_cpol,
    input  logic [DIV_WIDE-1:0] i_div,
    output logic                o_tick,
    output logic                o_lead,
    output logic                o_trail,
    output logic                o_sclk
);

    logic [DIV_WIDE-1:0] r_cnt;
    logic                r_sclk;

    // A tick marks the clk edge on which the next half-period begins; SCLK
    // changes on that same edge, so lead/trail describe the upcoming edge.
    assign o_tick  = i_run && (r_cnt == i_div);
    assign o_lead  = o_tick && i_shift && (r_sclk == i_cpol);
    assign o_trail = o_tick && i_shift && (r_sclk != i_cpol);
    assign o_sclk  = r_sclk;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else begin
            if (!i_run || o_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + DIV_WIDE'(1);
            end

            if (!i_shift) begin
                r_sclk <= i_cpol;
            end else if (o_tick) begin
                r_sclk <= ~r_sclk;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_master_core.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_core
// Description : Byte-oriented SPI master shift engine, bursts of N bytes under
//               one CS_N, all four SPI modes, programmable SCLK divider.
//               Optional macro SPI_LOOPBACK_EN adds loopback_i (MISO <- MOSI).
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_core
    import spi_pkg::*;
#(
    parameter int LEN_WIDE  = c_LEN_WIDE,
    parameter int DIV_WIDE  = c_DIV_WIDE,
    parameter int DATA_WIDE = c_DATA_WIDE
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [LEN_WIDE-1:0]  cmd_len_i,
    input  logic [DIV_WIDE-1:0]  clk_div_i,
    input  logic                 cpol_i,
    input  logic                 cpha_i,
    input  logic [DATA_WIDE-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic [DATA_WIDE-1:0] rx_data_o,
    output logic                 rx_valid_o,
    output logic                 busy_o,
`ifdef SPI_LOOPBACK_EN
    input  logic                 loopback_i,
`endif
    output logic                 spi_sclk_o,
    output logic                 spi_cs_n_o,
    output logic                 spi_mosi_o,
    input  logic                 spi_miso_i
);

    localparam int c_EDGES  = 2 * DATA_WIDE;
    localparam int c_EDGE_W = $clog2(c_EDGES);

    state_t               r_state;
    spi_mode_t            r_mode;
    logic [DIV_WIDE-1:0]  r_div;
    logic [LEN_WIDE-1:0]  r_remain;
    logic [c_EDGE_W-1:0]  r_edge;
    logic [DATA_WIDE-1:0] r_tx_sh;
    logic [DATA_WIDE-1:0] r_rx_sh;
    logic [DATA_WIDE-1:0] r_rx_data;
    logic                 r_cmd_ready;
    logic                 r_tx_ready;
    logic                 r_rx_valid;
    logic                 r_busy;
    logic                 r_cs_n;
    logic                 r_mosi;

    logic w_run;
    logic w_shift;
    logic w_cpol;
    logic w_tick;
    logic w_lead;
    logic w_trail;
    logic w_sclk;
    logic w_miso;
    logic w_sample;
    logic w_shift_out;
    logic w_last;

`ifdef SPI_LOOPBACK_EN
    assign w_miso = loopback_i ? r_mosi : spi_miso_i;
`else
    assign w_miso = spi_miso_i;
`endif

    assign w_run   = (r_state == c_ST_SETUP) || (r_state == c_ST_SHIFT) ||
                     (r_state == c_ST_HOLD);
    assign w_shift = (r_state == c_ST_SHIFT);
    // New CPOL reaches SCLK on the accept edge, together with CS_N falling,
    // so no spurious SCLK transition is seen while CS_N is low.
    assign w_cpol  = (r_state == c_ST_IDLE && cmd_valid_i) ? cpol_i : r_mode.cpol;

    assign w_last      = w_tick && w_shift && (r_edge == c_EDGE_W'(c_EDGES - 1));
    assign w_sample    = r_mode.cpha ? w_trail : w_lead;
    assign w_shift_out = (r_mode.cpha ? w_lead : w_trail) && !w_last;

    spi_sclk_gen #(
        .DIV_WIDE (DIV_WIDE)
    ) u_sclk_gen (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_run   (w_run),
        .i_shift (w_shift),
        .i_cpol  (w_cpol),
        .i_div   (r_div),
        .o_tick  (w_tick),
        .o_lead  (w_lead),
        .o_trail (w_trail),
        .o_sclk  (w_sclk)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= c_ST_IDLE;
            r_mode      <= '0;
            r_div       <= '0;
            r_remain    <= '0;
            r_edge      <= '0;
            r_tx_sh     <= '0;
            r_rx_sh     <= '0;
            r_rx_data   <= '0;
            r_cmd_ready <= 1'b1;
            r_tx_ready  <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_cs_n      <= 1'b1;
            r_mosi      <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (cmd_valid_i) begin
                        r_mode.cpol <= cpol_i;
                        r_mode.cpha <= cpha_i;
                        r_div       <= clk_div_i;
                        r_remain    <= cmd_len_i;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_cs_n      <= 1'b0;
                        r_state     <= c_ST_SETUP;
                    end
                end
                c_ST_SETUP: begin
                    if (w_tick) begin
                        r_tx_ready <= 1'b1;
                        r_state    <= c_ST_LOAD;
                    end
                end
                c_ST_LOAD: begin
                    if (tx_valid_i) begin
                        // CPHA=0 has already presented the MSB, so pre-shift;
                        // CPHA=1 presents the MSB on its first leading edge.
                        r_tx_sh    <= r_mode.cpha ? tx_data_i :
                                      {tx_data_i[DATA_WIDE-2:0], 1'b0};
                        r_mosi     <= tx_data_i[DATA_WIDE-1];
                        r_tx_ready <= 1'b0;
                        r_edge     <= '0;
                        r_state    <= c_ST_SHIFT;
                    end
                end
                c_ST_SHIFT: begin
                    if (w_tick) begin
                        r_edge <= r_edge + c_EDGE_W'(1);
                    end
                    if (w_sample) begin
                        r_rx_sh <= {r_rx_sh[DATA_WIDE-2:0], w_miso};
                    end
                    if (w_shift_out) begin
                        r_mosi  <= r_tx_sh[DATA_WIDE-1];
                        r_tx_sh <= {r_tx_sh[DATA_WIDE-2:0], 1'b0};
                    end
                    if (w_last) begin
                        // With CPHA=1 the eighth sample lands on this very edge.
                        r_rx_data  <= r_mode.cpha ? {r_rx_sh[DATA_WIDE-2:0], w_miso}
                                                  : r_rx_sh;
                        r_rx_valid <= 1'b1;
                        if (r_remain == '0) begin
                            r_state <= c_ST_HOLD;
                        end else begin
                            r_remain   <= r_remain - LEN_WIDE'(1);
                            r_tx_ready <= 1'b1;
                            r_state    <= c_ST_LOAD;
                        end
                    end
                end
                c_ST_HOLD: begin
                    if (w_tick) begin
                        r_cs_n      <= 1'b1;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o = r_cmd_ready;
    assign tx_ready_o  = r_tx_ready;
    assign rx_data_o   = r_rx_data;
    assign rx_valid_o  = r_rx_valid;
    assign busy_o      = r_busy;
    assign spi_sclk_o  = w_sclk;
    assign spi_cs_n_o  = r_cs_n;
    assign spi_mosi_o  = r_mosi;

endmodule
`default_nettype wire
